// File: rtl/channel_pkg.sv
// Shared types and constants for the noisy channel model: noise source
// selection, channel state encoding and maximal-length LFSR tap masks.
package channel_pkg;

  typedef enum logic {
    NM_JOHNSON,
    NM_LFSR
  } noise_mode_t;

  typedef enum logic [1:0] {
    IDLE,
    XMIT,
    REST
  } state_t;

  // Fibonacci tap masks for shift-left LFSRs, indexed by register width.
  localparam logic [7:0] LFSR_TAPS [3:8] = '{
    8'h06,  // x^3 + x^2 + 1
    8'h0C,  // x^4 + x^3 + 1
    8'h14,  // x^5 + x^3 + 1
    8'h30,  // x^6 + x^5 + 1
    8'h60,  // x^7 + x^6 + 1
    8'hB8   // x^8 + x^6 + x^5 + x^4 + 1
  };

endpackage

// File: rtl/noise_gen.sv
// Free-running noise source: sign-extended Johnson counter or Fibonacci LFSR,
// advancing on every clock.
module noise_gen import channel_pkg::*; #(
  parameter int          NOISE_W    = 5,
  parameter noise_mode_t NOISE_MODE = NM_JOHNSON,
  parameter int          LFSR_SEED  = 1
) (
  input  logic                      clk,
  input  logic                      reset,
  output logic signed [NOISE_W-1:0] noise
);

  generate
    if (NOISE_MODE == NM_LFSR) begin : g_lfsr
      localparam logic [NOISE_W-1:0] TAPS = LFSR_TAPS[NOISE_W][NOISE_W-1:0];
      logic [NOISE_W-1:0] r_lfsr;
      logic               w_fb;

      assign w_fb = ^(r_lfsr & TAPS);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_lfsr <= NOISE_W'(LFSR_SEED);
        else        r_lfsr <= {r_lfsr[NOISE_W-2:0], w_fb};
      end

      assign noise = r_lfsr;
    end else begin : g_johnson
      localparam int JW = NOISE_W - 2;
      logic [JW-1:0] r_john;
      logic [JW-1:0] w_john_next;

      // A one-bit Johnson ring degenerates to a toggle.
      if (JW == 1) begin : g_j1
        assign w_john_next = ~r_john;
      end else begin : g_jn
        assign w_john_next = {r_john[JW-2:0], ~r_john[JW-1]};
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_john <= '0;
        else        r_john <= w_john_next;
      end

      assign noise = {{2{r_john[JW-1]}}, r_john};
    end
  endgenerate

endmodule

// File: rtl/noisy_channel.sv
// Channel model adding noise to transmitted symbols with periodic rest bursts.
// Macro NOISY_CHANNEL_SAT_EN selects clamping instead of wrap on overflow.
module noisy_channel import channel_pkg::*; #(
  parameter int          DATA_W      = 9,
  parameter int          NOISE_W     = 5,
  parameter int          SAMPLE_DIV  = 4,
  parameter noise_mode_t NOISE_MODE  = NM_JOHNSON,
  parameter int          LFSR_SEED   = 1,
  parameter int          REST_PERIOD = 8,
  parameter int          REST_LEN    = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     IsTransmit,
  input  logic signed [DATA_W-1:0] channel_in,
  output logic signed [DATA_W-1:0] channel_out,
  output logic                     out_valid,
  output logic                     resting,
  output logic                     sat_flag
);

  localparam int DIV_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int SC_MAX = (REST_PERIOD > REST_LEN) ? REST_PERIOD : REST_LEN;
  localparam int SC_W   = (SC_MAX > 1) ? $clog2(SC_MAX) : 1;

  logic [DIV_W-1:0]         r_div;
  logic [SC_W-1:0]          r_scnt;
  state_t                   r_state;
  logic signed [DATA_W-1:0] r_out;
  logic                     r_valid;
  logic                     r_resting;
  logic                     r_sat;

  logic                     w_tick;
  logic signed [NOISE_W-1:0] w_noise;
  logic signed [DATA_W:0]   w_data_ext;
  logic signed [DATA_W:0]   w_noise_ext;
  logic signed [DATA_W:0]   w_sum;
  logic signed [DATA_W-1:0] w_narrow;
  logic                     w_clamp;
  logic                     w_last_xmit;
  logic                     w_last_rest;

  noise_gen #(
    .NOISE_W    (NOISE_W),
    .NOISE_MODE (NOISE_MODE),
    .LFSR_SEED  (LFSR_SEED)
  ) u_noise (
    .clk   (clk),
    .reset (reset),
    .noise (w_noise)
  );

  assign w_tick      = (r_div == DIV_W'(SAMPLE_DIV - 1));
  assign w_last_xmit = (int'(r_scnt) == REST_PERIOD - 1);
  assign w_last_rest = (int'(r_scnt) == REST_LEN - 1);

  // Noise-only samples reuse the adder with a zero data operand.
  assign w_data_ext  = (IsTransmit && r_state != REST) ?
                       {channel_in[DATA_W-1], channel_in} : '0;
  assign w_noise_ext = {{(DATA_W+1-NOISE_W){w_noise[NOISE_W-1]}}, w_noise};
  assign w_sum       = w_data_ext + w_noise_ext;

`ifdef NOISY_CHANNEL_SAT_EN
  always_comb begin
    w_clamp = (w_sum[DATA_W] != w_sum[DATA_W-1]);
    if (!w_clamp)          w_narrow = w_sum[DATA_W-1:0];
    else if (w_sum[DATA_W]) w_narrow = {1'b1, {(DATA_W-1){1'b0}}};
    else                   w_narrow = {1'b0, {(DATA_W-1){1'b1}}};
  end
`else
  assign w_narrow = DATA_W'(w_sum);
  assign w_clamp  = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_div <= '0;
    else if (w_tick) r_div <= '0;
    else r_div <= r_div + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_scnt    <= '0;
      r_out     <= '0;
      r_valid   <= 1'b0;
      r_resting <= 1'b0;
      r_sat     <= 1'b0;
    end else begin
      r_valid <= w_tick;
      r_sat   <= w_tick & w_clamp;
      if (w_tick) begin
        r_out <= w_narrow;
        if (!IsTransmit) begin
          r_state   <= IDLE;
          r_scnt    <= '0;
          r_resting <= 1'b0;
        end else begin
          case (r_state)
            // IDLE holds scnt at 0, so its first tick is transmit sample 0.
            IDLE, XMIT: begin
              if (w_last_xmit && REST_LEN > 0) begin
                r_state   <= REST;
                r_scnt    <= '0;
                r_resting <= 1'b1;
              end else begin
                r_state   <= XMIT;
                r_scnt    <= w_last_xmit ? '0 : r_scnt + 1'b1;
                r_resting <= 1'b0;
              end
            end
            REST: begin
              if (w_last_rest) begin
                r_state   <= XMIT;
                r_scnt    <= '0;
                r_resting <= 1'b0;
              end else begin
                r_scnt <= r_scnt + 1'b1;
              end
            end
            default: begin
              r_state   <= IDLE;
              r_scnt    <= '0;
              r_resting <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign channel_out = r_out;
  assign out_valid   = r_valid;
  assign resting     = r_resting;
  assign sat_flag    = r_sat;

endmodule

// File: tb/tb_noisy_channel.sv
// Scoreboard bench for noisy_channel: two Johnson configurations checked
// sample by sample, plus an LFSR instance checked for period and repeatability.
module tb_noisy_channel;
  import channel_pkg::*;

  localparam int DW   = 9;
  localparam int MAXV = 2**(DW-1) - 1;
  localparam int MINV = -(2**(DW-1));
  localparam int RP   = 8;
  localparam int SD [2] = '{4, 1};
  localparam int RL [2] = '{2, 0};
  localparam int JT [6] = '{0, 1, 3, -1, -2, -4};

  typedef struct {
    int val;
    int sat;
  } exp_t;

  logic                 clk;
  logic                 reset;
  logic                 tx;
  logic signed [DW-1:0] ch_in;

  logic signed [DW-1:0] o_out  [2];
  logic                 o_v    [2];
  logic                 o_rest [2];
  logic                 o_sat  [2];
  logic signed [DW-1:0] c_out;
  logic                 c_v, c_rest, c_sat;

  int   n_total = 0;
  int   n_bad   = 0;
  exp_t sb [2][$];
  int   m_cnt [2], m_div [2], m_scnt [2], m_st [2];
  int   c_log [$];
  int   c_ref [$];

  noisy_channel u_a (
    .clk(clk), .reset(reset), .IsTransmit(tx), .channel_in(ch_in),
    .channel_out(o_out[0]), .out_valid(o_v[0]), .resting(o_rest[0]), .sat_flag(o_sat[0])
  );

  noisy_channel #(.SAMPLE_DIV(1), .REST_LEN(0)) u_b (
    .clk(clk), .reset(reset), .IsTransmit(tx), .channel_in(ch_in),
    .channel_out(o_out[1]), .out_valid(o_v[1]), .resting(o_rest[1]), .sat_flag(o_sat[1])
  );

  noisy_channel #(.SAMPLE_DIV(1), .NOISE_MODE(NM_LFSR)) u_c (
    .clk(clk), .reset(reset), .IsTransmit(tx), .channel_in(ch_in),
    .channel_out(c_out), .out_valid(c_v), .resting(c_rest), .sat_flag(c_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic exp_t narrow(input int s);
    exp_t e;
    e.sat = 0;
`ifdef NOISY_CHANNEL_SAT_EN
    e.val = s;
    if (s > MAXV) begin e.val = MAXV; e.sat = 1; end
    else if (s < MINV) begin e.val = MINV; e.sat = 1; end
`else
    e.val = s & (2**DW - 1);
    if (e.val > MAXV) e.val -= 2**DW;
`endif
    return e;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_div[i] = 0; m_scnt[i] = 0; m_st[i] = 0;
      sb[i].delete();
    end
  endtask

  // One clock: advance the model for the coming edge, then compare afterwards.
  task automatic step();
    exp_t e;
    int   d;
    for (int i = 0; i < 2; i++) begin
      if (m_div[i] == SD[i] - 1) begin
        d = (tx && m_st[i] != 2) ? int'(ch_in) : 0;
        e = narrow(d + JT[m_cnt[i] % 6]);
        sb[i].push_back(e);
        if (!tx) begin
          m_st[i] = 0; m_scnt[i] = 0;
        end else if (m_st[i] != 2) begin
          if (m_scnt[i] == RP - 1 && RL[i] > 0) begin
            m_st[i] = 2; m_scnt[i] = 0;
          end else begin
            m_st[i] = 1;
            m_scnt[i] = (m_scnt[i] == RP - 1) ? 0 : m_scnt[i] + 1;
          end
        end else begin
          if (m_scnt[i] == RL[i] - 1) begin
            m_st[i] = 1; m_scnt[i] = 0;
          end else m_scnt[i]++;
        end
        m_div[i] = 0;
      end else m_div[i]++;
      m_cnt[i]++;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (o_v[i]) begin
        if (sb[i].size() == 0) check(i == 0 ? "a_extra_valid" : "b_extra_valid", 1, 0);
        else begin
          e = sb[i].pop_front();
          check(i == 0 ? "a_out" : "b_out", int'(o_out[i]), e.val);
          check(i == 0 ? "a_sat" : "b_sat", int'(o_sat[i]), e.sat);
          check(i == 0 ? "a_resting" : "b_resting", int'(o_rest[i]), int'(m_st[i] == 2));
        end
      end else if (sb[i].size() != 0) begin
        check(i == 0 ? "a_missing_valid" : "b_missing_valid", 0, 1);
        sb[i].delete();
      end
    end
    check("c_valid", int'(c_v), 1);
    c_log.push_back(int'(c_out));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a"}, int'({o_out[0], o_v[0], o_rest[0], o_sat[0]}), 0);
    check({tag, "_b"}, int'({o_out[1], o_v[1], o_rest[1], o_sat[1]}), 0);
    check({tag, "_c"}, int'({c_out, c_v, c_rest, c_sat}), 0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    c_log.delete();
  endtask

  task automatic lfsr_capture();
    tx = 1'b0;
    ch_in = '0;
    release_reset();
    repeat (33) step();
  endtask

  initial begin
    int found;
    int dups;
    int zeros;
    int mism;

    reset = 1'b0;
    tx    = 1'b0;
    ch_in = '0;
    model_reset();
    #23;
    check_reset_outputs("reset_state");
    release_reset();

    // Idle channel: noise only, first sample lands on the 4th edge.
    repeat (4) step();
    check("first_sample_valid", int'(o_v[0]), 1);
    check("first_sample_val", int'(o_out[0]), -1);
    repeat (26) step();

    // Steady transmit, covering bursts and rests on instance A.
    tx = 1'b1; ch_in = 9'sd100;
    repeat (60) step();

    // Positive and negative overflow.
    ch_in = 9'sd255;
    repeat (30) step();
    ch_in = -9'sd256;
    repeat (20) step();

    // Random data, with IsTransmit toggling between ticks.
    for (int k = 0; k < 200; k++) begin
      ch_in = DW'($urandom_range(0, 2**DW - 1));
      if ($urandom_range(0, 7) == 0) tx = ~tx;
      step();
    end

    // Reset asserted in the middle of a rest interval.
    tx = 1'b1; ch_in = 9'sd50;
    found = 0;
    for (int k = 0; k < 100 && found == 0; k++) begin
      step();
      if (m_st[0] == 2 && m_div[0] == 1) found = 1;
    end
    check("found_rest", found, 1);
    check("rest_resting_hi", int'(o_rest[0]), 1);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_rest_reset");
    @(posedge clk);
    #1;
    check_reset_outputs("held_reset");
    tx = 1'b0;
    release_reset();
    repeat (4) step();
    check("restart_sample_val", int'(o_out[0]), -1);
    check("restart_resting", int'(o_rest[0]), 0);
    repeat (8) step();

    // LFSR: 31 distinct non-zero values, then repeat; identical after reset.
    reset = 1'b0;
    lfsr_capture();
    check("lfsr_len", c_log.size(), 33);
    if (c_log.size() == 33) begin
      check("lfsr_first", c_log[0], 1);
      dups = 0; zeros = 0;
      for (int a = 0; a < 31; a++) begin
        if (c_log[a] == 0) zeros++;
        for (int b = a + 1; b < 31; b++) if (c_log[a] == c_log[b]) dups++;
      end
      check("lfsr_zero", zeros, 0);
      check("lfsr_dups", dups, 0);
      check("lfsr_period", c_log[31], c_log[0]);
    end
    c_ref = c_log;
    reset = 1'b0;
    #3;
    lfsr_capture();
    mism = 0;
    for (int a = 0; a < 33; a++) begin
      if (a >= c_log.size() || a >= c_ref.size() || c_log[a] != c_ref[a]) mism++;
    end
    check("lfsr_repeat", mism, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
